// File: rtl/mult_display_driver.sv
// Latches a 2-bit multiply (a, b, p) and scans it onto a 4-digit seven-segment display as A B _ P,
// flagging any product that disagrees with a*b.
module mult_display_driver #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic [3:0] p,
    input  logic       load,
    input  logic       clr,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       err
);

    localparam int unsigned DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {StEmpty, StShow} state_t;

    state_t           state;
    logic [1:0]       la;
    logic [1:0]       lb;
    logic [3:0]       lp;
    logic [DIV_W-1:0] div;
    logic [1:0]       idx;
    logic [3:0]       prod;
    logic [6:0]       seg_d;
    logic             dp_d;
    logic [3:0]       an_d;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    assign prod = {2'b00, a} * {2'b00, b};

    // clr outranks load, so a collision latches nothing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= StEmpty;
            la    <= '0;
            lb    <= '0;
            lp    <= '0;
            err   <= 1'b0;
        end else if (clr) begin
            state <= StEmpty;
            err   <= 1'b0;
        end else if (load) begin
            state <= StShow;
            la    <= a;
            lb    <= b;
            lp    <= p;
            err   <= (p != prod);
        end
    end

    // Free-running scan, independent of load/clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
            idx <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
            idx <= idx + 2'd1;
        end else begin
            div <= div + 1'b1;
        end
    end

    always_comb begin
        seg_d = SEG_DASH;
        dp_d  = 1'b1;
        an_d  = ~(4'b0001 << idx);
        if (state == StShow) begin
            unique case (idx)
                2'd0: begin
                    seg_d = (lp > 4'd9 || err) ? SEG_E : glyph(lp);
                    dp_d  = ~err;
                end
                2'd1:    seg_d = SEG_BLANK;
                2'd2:    seg_d = glyph({2'b00, lb});
                default: seg_d = glyph({2'b00, la});
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_BLANK;
            dp  <= 1'b1;
            an  <= 4'b1111;
        end else begin
            seg <= seg_d;
            dp  <= dp_d;
            an  <= an_d;
        end
    end

endmodule

// File: tb/tb_mult_display_driver.sv
// Directed plus randomized bench for mult_display_driver, checked against an arithmetic model of
// the display frame (digit index derived from the edge count since reset release).
module tb_mult_display_driver;

    localparam int unsigned R = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] a = '0;
    logic [1:0] b = '0;
    logic [3:0] p = '0;
    logic       load = 1'b0;
    logic       clr = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       err;

    mult_display_driver #(.REFRESH_DIV(R)) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .p    (p),
        .load (load),
        .clr  (clr),
        .seg  (seg),
        .dp   (dp),
        .an   (an),
        .err  (err)
    );

    always #5 clk = ~clk;

    int unsigned total  = 0;
    int unsigned passed = 0;

    logic [6:0] glyphs [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Reference model
    bit         m_show;
    int         m_la, m_lb, m_lp;
    bit         m_err;
    int         k;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] e_an;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, got, exp);
    endtask

    task automatic model_reset();
        m_show = 1'b0;
        m_la = 0; m_lb = 0; m_lp = 0;
        m_err = 1'b0;
        k = 0;
    endtask

    task automatic step(input bit ld, input bit cl, input int na, input int nb, input int np);
        int i;
        a = 2'(na); b = 2'(nb); p = 4'(np); load = ld; clr = cl;
        @(posedge clk);
        k++;
        i = ((k - 1) / R) % 4;
        e_an  = ~(4'b0001 << i);
        e_dp  = 1'b1;
        e_seg = 7'b0111111;
        if (m_show) begin
            if (i == 0) begin
                e_seg = (m_lp > 9 || m_err) ? 7'b0000110 : glyphs[m_lp];
                e_dp  = !m_err;
            end else if (i == 1) e_seg = 7'b1111111;
            else if (i == 2) e_seg = glyphs[m_lb];
            else e_seg = glyphs[m_la];
        end
        if (cl) begin
            m_show = 1'b0;
            m_err  = 1'b0;
        end else if (ld) begin
            m_show = 1'b1;
            m_la = na; m_lb = nb; m_lp = np;
            m_err = (np != na * nb);
        end
        #1;
        load = 1'b0; clr = 1'b0;
        chk("an", {4'b0, an}, {4'b0, e_an});
        chk("seg", {1'b0, seg}, {1'b0, e_seg});
        chk("dp", {7'b0, dp}, {7'b0, e_dp});
        chk("err", {7'b0, err}, {7'b0, m_err});
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_an"}, {4'b0, an}, 8'h0f);
        chk({tag, "_seg"}, {1'b0, seg}, 8'h7f);
        chk({tag, "_dp"}, {7'b0, dp}, 8'h01);
        chk({tag, "_err"}, {7'b0, err}, 8'h00);
    endtask

    initial begin
        int r, na, nb, np;
        model_reset();
        @(posedge clk);
        #1;
        chk_reset_vals("rst_hold");
        rst = 1'b0;

        // EMPTY scan
        idle(32);

        // Correct product
        step(1'b1, 1'b0, 3, 2, 6);
        idle(16);

        // Mismatch then corrected reload
        step(1'b1, 1'b0, 3, 3, 8);
        chk("mismatch_err", {7'b0, err}, 8'h01);
        idle(16);
        step(1'b1, 1'b0, 3, 3, 9);
        idle(16);

        // Out-of-range product
        step(1'b1, 1'b0, 1, 1, 12);
        idle(16);

        // clr/load collision, then a mid-dwell reload
        step(1'b1, 1'b1, 2, 0, 0);
        idle(9);
        step(1'b1, 1'b0, 2, 1, 2);
        idle(16);

        // Async reset mid-frame at index 2
        step(1'b1, 1'b0, 3, 1, 3);
        for (int j = 0; j < 16 && (((k - 1) / R) % 4) != 2; j++) idle(1);
        chk("reach_idx2", {4'b0, an}, 8'h0b);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        chk_reset_vals("async_hold");
        rst = 1'b0;
        idle(20);

        // Randomized traffic
        for (int j = 0; j < 300; j++) begin
            r  = int'($urandom_range(0, 15));
            na = int'($urandom_range(0, 3));
            nb = int'($urandom_range(0, 3));
            np = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : na * nb;
            step(r < 4, r == 15, na, nb, np);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
